cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- BW_PROCESSOR_DATA, 32, data width of a broadcast result.
- BW_TAG, 6, reservation-station tag width.
- NUM_KINDS_OF_UNIT, 4, number of requesting functional units (N).
- FIFO_DEPTH, 2, entries per requester queue (power of 2, ≥2).

REQ-002 Ports SHALL be, one per line (unit index k: INT=0, MUL=1, BRANCH=2, LOAD_STORE=3):
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_flush  input  1  synchronous discard of all pending results.
- i_req_valid  input  N  unit k offers a result.
- i_req_ready  output  N  unit k's queue can accept.
- i_req_tag  input  N x BW_TAG  producing tag per unit.
- i_req_data  input  N x BW_PROCESSOR_DATA  result per unit.
- o_cdb_valid  output  1  broadcast valid; no backpressure.
- o_cdb_tag  output  BW_TAG  broadcast tag.
- o_cdb_data  output  BW_PROCESSOR_DATA  broadcast data.
- o_cdb_src  output  clog2(N)  index of the unit that won the broadcast.
- o_busy  output  1  any queue non-empty or o_cdb_valid high.

Function
REQ-003 Each unit SHALL own a FIFO_DEPTH-entry FIFO holding {tag, data}; push occurs when i_req_valid[k] & i_req_ready[k].
REQ-004 i_req_ready[k] SHALL be driven only by stored occupancy (count < FIFO_DEPTH); no combinational path from any valid or from the grant.
REQ-005 A full FIFO SHALL deassert ready even in a cycle where it is popped; the freed slot is offered the following cycle.
REQ-006 Each cycle, at most one non-empty FIFO SHALL be granted, chosen round-robin: search order starts at rr_ptr and wraps modulo N.
REQ-007 On a grant to unit g, rr_ptr SHALL update to (g+1) mod N; with no grant, rr_ptr holds.
REQ-008 The granted head SHALL be popped, and {tag, data, g} SHALL be registered into o_cdb_tag/o_cdb_data/o_cdb_src with o_cdb_valid=1 on the same edge.
REQ-009 In a cycle with no grant, o_cdb_valid SHALL be 0 next cycle; tag/data/src hold their previous values.
REQ-010 Latency from a push into an empty FIFO with that unit winning arbitration SHALL be 2 cycles (push at edge t, grant in cycle t+1, o_cdb_valid in cycle t+2).
REQ-011 Sustained throughput SHALL be one broadcast per cycle while any FIFO is non-empty.
REQ-012 Simultaneous push and pop on the same non-full FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-013 Starvation bound: a non-empty FIFO SHALL be granted within N cycles.
REQ-014 When i_flush=1, next cycle all FIFOs SHALL be empty and o_cdb_valid=0.
REQ-015 Pushes and grants in a flush cycle SHALL be discarded, and rr_ptr SHALL be unchanged by a flush.
REQ-016 o_busy SHALL be the OR of all FIFO non-empty flags and o_cdb_valid.

Reset
REQ-017 While rst_n=0: all FIFO counts and pointers = 0; rr_ptr = 0 (INT first); o_cdb_valid = 0; o_cdb_tag = 0; o_cdb_data = 0; o_cdb_src = 0; i_req_ready = all ones; o_busy = 0.
REQ-018 Reset asserted mid-operation SHALL discard all queued and in-flight results immediately, with no broadcast after deassertion until new pushes occur.

Structure
REQ-019 Unit index constants (INT, MUL, BRANCH, LOAD_STORE) and the {tag, data} entry struct typedef SHALL live in the shared definitions package.
REQ-020 The per-unit queue SHALL be a sub-module cdb_req_fifo, instantiated N times with parameters BW_TAG, BW_PROCESSOR_DATA and FIFO_DEPTH.
REQ-021 Arbitration and the output register SHALL stay in cdb_arbiter.

Verification
REQ-022 Single request: reset, push MUL tag=5 data=0x1234 at edge 1 -> o_cdb_valid=1, tag=5, data=0x1234, src=1 in cycle 3 only.
REQ-023 All four units push simultaneously (tags 1,2,3,4) with rr_ptr=0 -> broadcasts in order src 0,1,2,3 on four consecutive cycles; rr_ptr ends at 0.
REQ-024 Backpressure: hold INT valid with tags 10,11,12 and no other requests -> ready drops after 2 accepts; all three broadcast in order, with no loss or duplication.
REQ-025 Fairness: INT and LOAD_STORE continuously valid -> grants alternate 0,3,0,3…; no unit waits more than N cycles.
REQ-026 Flush with 2 entries queued in BRANCH and o_cdb_valid=1 -> o_cdb_valid=0 and o_busy=0 the next cycle; a push in the flush cycle is never broadcast.
REQ-027 Assert rst_n=0 mid-stream with 3 entries pending -> outputs at reset values immediately; no stale broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: unit indices and queue entry layout.
package cdb_arbiter_pkg;

   localparam int unsigned UNIT_INT        = 0;
   localparam int unsigned UNIT_MUL        = 1;
   localparam int unsigned UNIT_BRANCH     = 2;
   localparam int unsigned UNIT_LOAD_STORE = 3;
   localparam int unsigned NUM_UNITS       = 4;

   localparam int unsigned CDB_TAG_W  = 6;
   localparam int unsigned CDB_DATA_W = 32;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_entry_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-unit result queue; ready is a flop derived from next occupancy, so it never
// depends combinationally on valid or pop.
module cdb_req_fifo #(
   parameter int unsigned BW_TAG            = 6,
   parameter int unsigned BW_PROCESSOR_DATA = 32,
   parameter int unsigned FIFO_DEPTH        = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [BW_TAG-1:0]            i_tag,
   input  logic [BW_PROCESSOR_DATA-1:0] i_data,
   output logic                         o_ready,
   output logic                         o_not_empty,
   output logic [BW_TAG-1:0]            o_tag,
   output logic [BW_PROCESSOR_DATA-1:0] o_data
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [FIFO_DEPTH-1:0][BW_TAG-1:0]            tag_mem_q;
   logic [FIFO_DEPTH-1:0][BW_PROCESSOR_DATA-1:0] data_mem_q;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             do_push, do_pop, we;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_push  = i_push && ready_q;
      do_pop   = i_pop && (cnt_q != '0);
      we       = 1'b0;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
      ready_d = (cnt_d < CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem_q[wr_ptr_q]  <= i_tag;
         data_mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_ready     = ready_q;
   assign o_not_empty = (cnt_q != '0);
   assign o_tag       = tag_mem_q[rd_ptr_q];
   assign o_data      = data_mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains per-unit result queues onto a single registered
// common data bus, one broadcast per cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned BW_PROCESSOR_DATA = 32,
   parameter int unsigned BW_TAG            = 6,
   parameter int unsigned NUM_KINDS_OF_UNIT = 4,
   parameter int unsigned FIFO_DEPTH        = 2,
   localparam int unsigned SRC_W            = (NUM_KINDS_OF_UNIT > 1) ? $clog2(NUM_KINDS_OF_UNIT) : 1
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 i_flush,
   input  logic [NUM_KINDS_OF_UNIT-1:0]                         i_req_valid,
   output logic [NUM_KINDS_OF_UNIT-1:0]                         i_req_ready,
   input  logic [NUM_KINDS_OF_UNIT-1:0][BW_TAG-1:0]             i_req_tag,
   input  logic [NUM_KINDS_OF_UNIT-1:0][BW_PROCESSOR_DATA-1:0]  i_req_data,
   output logic                                                 o_cdb_valid,
   output logic [BW_TAG-1:0]                                    o_cdb_tag,
   output logic [BW_PROCESSOR_DATA-1:0]                         o_cdb_data,
   output logic [SRC_W-1:0]                                     o_cdb_src,
   output logic                                                 o_busy
);

   logic [NUM_KINDS_OF_UNIT-1:0]                        not_empty;
   logic [NUM_KINDS_OF_UNIT-1:0]                        pop;
   logic [NUM_KINDS_OF_UNIT-1:0][BW_TAG-1:0]            head_tag;
   logic [NUM_KINDS_OF_UNIT-1:0][BW_PROCESSOR_DATA-1:0] head_data;

   logic                         gnt_valid;
   logic [SRC_W-1:0]             gnt_idx;
   logic [SRC_W-1:0]             cand;
   int unsigned                  sum;

   logic [SRC_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic                         cdb_valid_q, cdb_valid_d;
   logic [BW_TAG-1:0]            cdb_tag_q, cdb_tag_d;
   logic [BW_PROCESSOR_DATA-1:0] cdb_data_q, cdb_data_d;
   logic [SRC_W-1:0]             cdb_src_q, cdb_src_d;

   for (genvar k = 0; k < NUM_KINDS_OF_UNIT; k++) begin : g_fifo
      assign pop[k] = gnt_valid && !i_flush && (gnt_idx == SRC_W'(k));

      cdb_req_fifo #(
         .BW_TAG            (BW_TAG),
         .BW_PROCESSOR_DATA (BW_PROCESSOR_DATA),
         .FIFO_DEPTH        (FIFO_DEPTH)
      ) u_fifo (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_flush     (i_flush),
         .i_push      (i_req_valid[k]),
         .i_pop       (pop[k]),
         .i_tag       (i_req_tag[k]),
         .i_data      (i_req_data[k]),
         .o_ready     (i_req_ready[k]),
         .o_not_empty (not_empty[k]),
         .o_tag       (head_tag[k]),
         .o_data      (head_data[k])
      );
   end

   // First non-empty queue at or after rr_ptr, wrapping modulo N.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      sum       = 0;
      for (int unsigned i = 0; i < NUM_KINDS_OF_UNIT; i++) begin
         sum = 32'(rr_ptr_q) + i;
         if (sum >= NUM_KINDS_OF_UNIT) begin
            sum = sum - NUM_KINDS_OF_UNIT;
         end
         cand = SRC_W'(sum);
         if (!gnt_valid && not_empty[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      cdb_valid_d = gnt_valid && !i_flush;
      if (cdb_valid_d) begin
         cdb_tag_d  = head_tag[gnt_idx];
         cdb_data_d = head_data[gnt_idx];
         cdb_src_d  = gnt_idx;
         rr_ptr_d   = (gnt_idx == SRC_W'(NUM_KINDS_OF_UNIT - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= SRC_W'(UNIT_INT);
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign o_cdb_valid = cdb_valid_q;
   assign o_cdb_tag   = cdb_tag_q;
   assign o_cdb_data  = cdb_data_q;
   assign o_cdb_src   = cdb_src_q;
   assign o_busy      = (|not_empty) || cdb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed broadcast sequences.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [3:0][5:0]  req_tag;
   logic [3:0][31:0] req_data;
   logic             cdb_valid;
   logic [5:0]       cdb_tag;
   logic [31:0]      cdb_data;
   logic [1:0]       cdb_src;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   cdb_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (flush),
      .i_req_valid (req_valid),
      .i_req_ready (req_ready),
      .i_req_tag   (req_tag),
      .i_req_data  (req_data),
      .o_cdb_valid (cdb_valid),
      .o_cdb_tag   (cdb_tag),
      .o_cdb_data  (cdb_data),
      .o_cdb_src   (cdb_src),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      req_valid = '0;
      req_tag   = '0;
      req_data  = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      clear_req();
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] bt[$];
      logic [1:0] bs[$];
      logic       rlog [1:10];
      logic       acc;
      int         idx, nvalid, c0, c3;
      logic [5:0] exp_tag [6];
      logic [1:0] exp_src [6];

      // Reset values
      rst_n = 1'b0;
      flush = 1'b0;
      clear_req();
      step();
      check("rst_ready", 64'(req_ready), 64'hf);
      check("rst_valid", 64'(cdb_valid), 64'h0);
      check("rst_tag", 64'(cdb_tag), 64'h0);
      check("rst_data", 64'(cdb_data), 64'h0);
      check("rst_src", 64'(cdb_src), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      step();
      rst_n = 1'b1;

      // Single MUL request: visible two edges after the push, for one cycle
      req_valid[UNIT_MUL] = 1'b1;
      req_tag[UNIT_MUL]   = 6'd5;
      req_data[UNIT_MUL]  = 32'h1234;
      step();
      clear_req();
      check("single_c2_valid", 64'(cdb_valid), 64'h0);
      check("single_c2_busy", 64'(busy), 64'h1);
      step();
      check("single_valid", 64'(cdb_valid), 64'h1);
      check("single_tag", 64'(cdb_tag), 64'd5);
      check("single_data", 64'(cdb_data), 64'h1234);
      check("single_src", 64'(cdb_src), 64'd1);
      step();
      check("single_c4_valid", 64'(cdb_valid), 64'h0);
      check("single_c4_busy", 64'(busy), 64'h0);

      // All four push together from rr_ptr=0
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req_valid[k] = 1'b1;
         req_tag[k]   = 6'(k + 1);
         req_data[k]  = 32'(32'hA0 + k);
      end
      step();
      clear_req();
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("all4_valid%0d", k), 64'(cdb_valid), 64'h1);
         check($sformatf("all4_src%0d", k), 64'(cdb_src), 64'(k));
         check($sformatf("all4_tag%0d", k), 64'(cdb_tag), 64'(k + 1));
      end
      step();
      check("all4_idle", 64'(cdb_valid), 64'h0);
      // rr_ptr back at 0: INT must beat LOAD_STORE
      req_valid = 4'b1001;
      step();
      clear_req();
      step();
      check("rr_wrap_first", 64'(cdb_src), 64'd0);
      step();
      check("rr_wrap_second", 64'(cdb_src), 64'd3);

      // Backpressure on INT while the other units hold the bus
      do_reset();
      req_valid = 4'b1110;
      req_tag[1] = 6'd50;
      req_tag[2] = 6'd60;
      req_tag[3] = 6'd70;
      idx = 0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (cyc >= 2) begin
            req_valid[3:1] = 3'b000;
            req_valid[0]   = (idx < 3);
            req_tag[0]     = 6'(10 + idx);
         end
         rlog[cyc] = req_ready[0];
         acc = req_valid[0] && req_ready[0];
         step();
         if (acc) idx++;
         if (cdb_valid) begin
            bt.push_back(cdb_tag);
            bs.push_back(cdb_src);
         end
      end
      clear_req();
      check("bp_rdy_c3", 64'(rlog[3]), 64'h1);
      check("bp_rdy_c4", 64'(rlog[4]), 64'h0);
      check("bp_rdy_c5_popped_full", 64'(rlog[5]), 64'h0);
      check("bp_rdy_c6", 64'(rlog[6]), 64'h1);
      check("bp_accepts", 64'(idx), 64'd3);
      check("bp_bcast_count", 64'(bt.size()), 64'd6);
      exp_tag = '{6'd50, 6'd60, 6'd70, 6'd10, 6'd11, 6'd12};
      exp_src = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
      for (int i = 0; i < 6; i++) begin
         check($sformatf("bp_tag%0d", i), 64'((i < bt.size()) ? bt[i] : 6'h3f), 64'(exp_tag[i]));
         check($sformatf("bp_src%0d", i), 64'((i < bs.size()) ? bs[i] : 2'bxx), 64'(exp_src[i]));
      end

      // Fairness: INT and LOAD_STORE both streaming
      do_reset();
      bt.delete();
      bs.delete();
      c0 = 0;
      c3 = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         req_valid  = 4'b1001;
         req_tag[0] = 6'(c0);
         req_tag[3] = 6'(32 + c3);
         acc = req_ready[0];
         idx = int'(req_ready[3]);
         step();
         if (acc) c0++;
         if (idx != 0) c3++;
         if (cdb_valid) begin
            bt.push_back(cdb_tag);
            bs.push_back(cdb_src);
         end
      end
      clear_req();
      check("fair_count", 64'(bt.size()), 64'd11);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("fair_src%0d", i), 64'((i < bs.size()) ? bs[i] : 2'bxx),
               64'((i % 2 == 0) ? 0 : 3));
         check($sformatf("fair_tag%0d", i), 64'((i < bt.size()) ? bt[i] : 6'h3f),
               64'((i % 2 == 0) ? i / 2 : 32 + i / 2));
      end

      // Flush with BRANCH holding two entries and a broadcast in flight
      do_reset();
      req_valid = 4'b0101;
      req_tag[0] = 6'd40;
      req_tag[2] = 6'd30;
      step();
      req_valid = 4'b0100;
      req_tag[2] = 6'd31;
      step();
      check("fl_pre_valid", 64'(cdb_valid), 64'h1);
      check("fl_pre_tag", 64'(cdb_tag), 64'd40);
      check("fl_pre_ready_br", 64'(req_ready[2]), 64'h0);
      flush = 1'b1;
      req_valid = 4'b0010;
      req_tag[1] = 6'd33;
      step();
      flush = 1'b0;
      clear_req();
      check("fl_valid", 64'(cdb_valid), 64'h0);
      check("fl_busy", 64'(busy), 64'h0);
      check("fl_ready", 64'(req_ready), 64'hf);
      nvalid = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (cdb_valid) nvalid++;
      end
      check("fl_no_stale", 64'(nvalid), 64'd0);
      // rr_ptr still 1 after flush: MUL beats INT
      req_valid = 4'b0011;
      step();
      clear_req();
      step();
      check("fl_rr_first", 64'(cdb_src), 64'd1);
      step();
      check("fl_rr_second", 64'(cdb_src), 64'd0);

      // Reset mid-stream with three entries pending
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req_valid[k] = 1'b1;
         req_tag[k]   = 6'(k + 1);
         req_data[k]  = 32'(32'h55 + k);
      end
      step();
      clear_req();
      step();
      check("mr_pre_valid", 64'(cdb_valid), 64'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mr_valid", 64'(cdb_valid), 64'h0);
      check("mr_tag", 64'(cdb_tag), 64'h0);
      check("mr_data", 64'(cdb_data), 64'h0);
      check("mr_src", 64'(cdb_src), 64'h0);
      check("mr_busy", 64'(busy), 64'h0);
      check("mr_ready", 64'(req_ready), 64'hf);
      step();
      rst_n = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (cdb_valid) nvalid++;
      end
      check("mr_no_stale", 64'(nvalid), 64'd0);
      check("mr_idle_busy", 64'(busy), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
